seq_detector_prog: RTL
======================

# seq_detector_prog

Programmable multi-pattern serial sequence detector. It is the parametrised successor to the team's fixed single-pattern Moore detector. It watches a qualified serial bit stream `x` and holds NPAT independently programmable patterns, each 2..MAX_LEN bits long. It selects overlapping or non-overlapping match mode and keeps a saturating match counter. It sits between a serial front-end and control logic that needs per-pattern match flags.

## Interface
Parameters:
- MAX_LEN, 8, maximum pattern length in bits (≥2)
- NPAT, 2, number of pattern slots (≥1)
- CNT_W, 8, match counter width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = detect (RUN), 0 = configure (IDLE)
- overlap  in  1  1 = overlapping matches, 0 = non-overlapping; sampled only in RUN
- cfg_we  in  1  pattern write strobe; honoured only in IDLE
- cfg_sel  in  max(1,$clog2(NPAT))  slot to write
- cfg_pat  in  MAX_LEN  pattern bits; cfg_pat[len-1] is received first, cfg_pat[0] last
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length
- cfg_en  in  NPAT  per-slot enable, level
- x_valid  in  1  qualifies x
- x  in  1  serial data
- z  out  1  registered one-cycle pulse: any slot matched
- z_id  out  NPAT  registered one-hot-per-slot match flags, valid with z
- match_cnt  out  CNT_W  saturating count of match events
- cnt_clr  in  1  synchronous counter clear
- state  out  1  0 = IDLE, 1 = RUN

## Operation
- FSM has two states: IDLE and RUN.
  - IDLE→RUN when run=1; RUN→IDLE when run=0.
  - Every transition clears the history fill count; stored patterns are kept.
- IDLE behaviour:
  - x is ignored; z and z_id are 0.
  - When cfg_we=1, slot cfg_sel is loaded with cfg_pat and cfg_len.
  - The write is ignored if cfg_sel ≥ NPAT or cfg_len ∉ [2, MAX_LEN].
  - Bits of cfg_pat above cfg_len are don't-care.
- RUN history:
  - Each cycle with x_valid=1 shifts x into the LSB of history register hist[MAX_LEN-1:0].
  - fill increments, saturating at MAX_LEN.
  - Cycles with x_valid=0 change nothing in the history.
- Match rule for slot p:
  - cfg_en[p]=1, and
  - fill_next ≥ len_p, and
  - the low len_p bits of hist_next equal the low len_p bits of pat_p.
  - A match is evaluated only on valid cycles.
- Match event: any slot matches.
  - z=1, z_id = vector of all matching slots, so simultaneous matches are all flagged.
  - match_cnt increments by 1 per event, not per slot.
  - match_cnt saturates at 2^CNT_W−1.
- Overlap mode: the history is untouched after a match.
- Non-overlap mode: a match event sets fill to 0, so the next match needs len fresh valid bits.
- cnt_clr=1 sets match_cnt to 0. It has priority over a same-cycle match increment.
- cfg_en changes take effect on the next evaluated bit. They do not clear the history.

## Timing
- Reset (asynchronous, rst_n=0) sets:
  - state=IDLE, hist=0, fill=0, z=0, z_id=0, match_cnt=0
  - every slot to pat=0, len=MAX_LEN
- Latency:
  - z and z_id assert at the same rising edge that samples the final pattern bit. They are visible in the following cycle.
  - The pulse is exactly one clock wide.
  - Back-to-back matches on consecutive valid cycles give consecutive pulses.
- match_cnt updates on the same edge as z.
- rst_n asserted mid-pattern: a partial pattern is discarded. Detection after release needs a full len bits.
- run deasserted on the final-bit cycle: the IDLE transition wins, with no pulse and no count.
- Config writes become effective on the next cycle.

## Structure
- Shared package `seq_det_pkg`:
  - state enum (IDLE, RUN)
  - localparams for the cfg_sel and cfg_len widths
- One natural sub-module, `seq_pat_match`: per-slot comparator (stored pattern, length, enable, history → match bit), instantiated NPAT times via generate.
- The top module holds the FSM, history, fill, counter and output registers.

## Test plan
All scenarios use MAX_LEN=8, NPAT=2, CNT_W=8 unless stated.
1. Reset: with rst_n low, drive x_valid=1 and toggle x → z=0, z_id=00, match_cnt=0, state=0. Program slot0 = 0101 (len 4) and check no pulse until run=1.
2. Overlap: slot0 = 0101 len 4, overlap=1, stream 0,1,0,1,0,1 → z pulses after bits 4 and 6, z_id=01, match_cnt=2.
3. Non-overlap: same pattern, overlap=0, stream 0,1,0,1,0,1,0,1 → pulses after bits 4 and 8 only, match_cnt=2.
4. Simultaneous slots: slot0 = 0110 len 4, slot1 = 110 len 3, stream 0,1,1,0 → single pulse with z_id=11, match_cnt=1. Toggle x_valid low between bits with x flipping → identical result.
5. Saturation: CNT_W=4, 20 overlapping matches of 0101 → match_cnt=15. Assert cnt_clr on the same cycle as a match → match_cnt=0 while z=1.
6. Mid-stream disturbance:
   - Feed 0,1,0, pulse rst_n low, then feed 1 → no pulse.
   - Feed 0,1,0, drop run for one cycle, feed 1 → no pulse.
   - cfg_we in RUN with cfg_pat=1111 → slot unchanged.

Source files
------------

// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------
// seq_det_pkg : shared types and width helpers for seq_detector_prog
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package seq_det_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int sel_width(input int npat);
    return (npat > 1) ? $clog2(npat) : 1;
  endfunction

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Widths for the default build (MAX_LEN=8, NPAT=2)
  localparam int CFG_SEL_W = sel_width(2);
  localparam int CFG_LEN_W = len_width(8);

endpackage

`default_nettype wire

// File: rtl/seq_pat_match.sv
// ---------------------------------------------------------------
// seq_pat_match : compares the low len bits of the history to one stored pattern
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module seq_pat_match #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  input  logic               en,
  input  logic [MAX_LEN-1:0] hist,
  input  logic [LEN_W-1:0]   fill,
  output logic               match
);

  logic [MAX_LEN-1:0] diff;
  logic               bits_eq;

  always_comb begin
    diff    = hist ^ pat;
    bits_eq = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < len) && diff[i]) begin
        bits_eq = 1'b0;
      end
    end
    match = en && (fill >= len) && bits_eq;
  end

endmodule

`default_nettype wire

// File: rtl/seq_detector_prog.sv
// ---------------------------------------------------------------
// seq_detector_prog : programmable multi-pattern serial sequence detector
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int NPAT    = 2,
  parameter int CNT_W   = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            run,
  input  logic                            overlap,
  input  logic                            cfg_we,
  input  logic [sel_width(NPAT)-1:0]      cfg_sel,
  input  logic [MAX_LEN-1:0]              cfg_pat,
  input  logic [len_width(MAX_LEN)-1:0]   cfg_len,
  input  logic [NPAT-1:0]                 cfg_en,
  input  logic                            x_valid,
  input  logic                            x,
  output logic                            z,
  output logic [NPAT-1:0]                 z_id,
  output logic [CNT_W-1:0]                match_cnt,
  input  logic                            cnt_clr,
  output logic                            state
);

  localparam int SEL_W = sel_width(NPAT);
  localparam int LEN_W = len_width(MAX_LEN);

  state_e                         state_q, state_d;
  logic [MAX_LEN-1:0]             hist_q, hist_d, hist_shift;
  logic [LEN_W-1:0]               fill_q, fill_d, fill_inc;
  logic [NPAT-1:0][MAX_LEN-1:0]   pat_q, pat_d;
  logic [NPAT-1:0][LEN_W-1:0]     len_q, len_d;
  logic                           z_q, z_d;
  logic [NPAT-1:0]                z_id_q, z_id_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [NPAT-1:0]                hit;
  logic                           eval, any_hit, cfg_ok;

  // Candidate history/fill as they would be after this bit; slots match against these
  assign hist_shift = {hist_q[MAX_LEN-2:0], x};
  assign fill_inc   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
  assign eval       = (state_q == ST_RUN) && run && x_valid;
  assign any_hit    = |hit;
  assign cfg_ok     = ({1'b0, cfg_sel} < (SEL_W + 1)'(NPAT)) &&
                      (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(MAX_LEN));

  genvar g;
  generate
    for (g = 0; g < NPAT; g++) begin : g_slot
      seq_pat_match #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
      ) u_match (
        .pat   (pat_q[g]),
        .len   (len_q[g]),
        .en    (cfg_en[g]),
        .hist  (hist_shift),
        .fill  (fill_inc),
        .match (hit[g])
      );
    end
  endgenerate

  always_comb begin
    state_d = run ? ST_RUN : ST_IDLE;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    z_d     = 1'b0;
    z_id_d  = '0;
    cnt_d   = cnt_q;

    if (eval) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
      if (any_hit) begin
        z_d    = 1'b1;
        z_id_d = hit;
        if (!overlap) fill_d = '0;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
    end

    if (state_d != state_q) fill_d = '0;

    if ((state_q == ST_IDLE) && cfg_we && cfg_ok) begin
      pat_d[cfg_sel] = cfg_pat;
      len_d[cfg_sel] = cfg_len;
    end

    if (cnt_clr) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      for (int i = 0; i < NPAT; i++) begin
        len_q[i] <= LEN_W'(MAX_LEN);
      end
      z_q     <= 1'b0;
      z_id_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      z_q     <= z_d;
      z_id_q  <= z_id_d;
      cnt_q   <= cnt_d;
    end
  end

  assign z         = z_q;
  assign z_id      = z_id_q;
  assign match_cnt = cnt_q;
  assign state     = state_q;

endmodule

`default_nettype wire
